sid_wave_rom_arbiter: RTL
=========================

Name: sid_wave_rom_arbiter

Overview:
- Shares one registered combined-waveform ROM bank among the three SID 8580 voices.
- The bank holds the ps, pt, st and pst tables: 12-bit index, 8-bit output, 1-cycle read latency.
- Each voice posts a lookup request with its 12-bit wave index and table select. The block arbitrates round-robin, drives the shared ROM address, then returns the 8-bit result into a per-voice output register with a valid strobe.
- Sits between the voice oscillators and the waveform selector/DAC path.

Parameters:
- NVOICE, 3, number of requesters (fixed at 3; not intended to change).
- AW, 12, wave index width.
- DW, 8, table output width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  per-voice lookup request (level).
- wave0, wave1, wave2  in  12 each  per-voice wave index.
- sel0, sel1, sel2  in  2 each  table select (0=ps, 1=pt, 2=st, 3=pst).
- ack  out  3  one-cycle pulse: request accepted, inputs captured.
- rom_en  out  1  ROM read enable.
- rom_addr  out  12  shared ROM index.
- rom_sel  out  2  shared ROM table select.
- rom_data  in  8  ROM output; valid one edge after rom_en/rom_addr are sampled.
- out0, out1, out2  out  8 each  per-voice lookup result (held).
- out_valid  out  3  one-cycle pulse when the matching outN updates.

Behaviour:
- Reset (async, immediate), all registers cleared:
  - state = IDLE
  - ack = 0, out_valid = 0, rom_en = 0
  - rom_addr = 0, rom_sel = 0
  - out0/1/2 = 0x00
  - RR pointer last = 2, so voice 0 has highest priority first
  - any in-flight lookup is discarded.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, WAIT, CAPT.
- Grant edge (state IDLE or CAPT, any req bit high):
  - Winner v = first set bit searching last+1, last+2, last (mod 3).
  - Register: rom_addr <= waveV, rom_sel <= selV, rom_en <= 1, ack[v] <= 1, cur <= v, last <= v.
  - Next state = WAIT.
- No request in IDLE: stay in IDLE with ack = 0 and rom_en = 0.
- WAIT (ROM samples address at this edge): rom_en <= 0, ack <= 0, state <= CAPT.
- CAPT edge:
  - out[cur] <= rom_data, out_valid[cur] <= 1.
  - The same edge performs a new grant if any req is high (-> WAIT); otherwise -> IDLE.
- Throughput and latency:
  - One lookup per 2 clocks when saturated.
  - Grant edge to out_valid high: 2 edges.
- out_valid and ack are single-cycle pulses and are cleared on every edge not setting them.
- Request semantics:
  - req is sampled only at grant edges.
  - A voice still holding req at a later grant edge is served again (continuous refresh).
  - Dropping req before being granted cancels the lookup, with no ack.
- Inputs are captured at the grant edge; changes afterwards do not affect the in-flight lookup.
- Simultaneous requests from all three voices, saturated order: 0, 1, 2, 0, …
- outN holds its value until that voice's next completed lookup.

Optional Feature:
- SID_WAVE_CACHE_EN defined:
  - Per-voice cache of last served {sel, wave} plus a hit-valid bit; hit-valid bits cleared on reset.
  - At any edge, a requesting voice whose current {selN, waveN} equals its cache entry (hit-valid set) is excluded from arbitration.
  - Instead it gets ack[N] = 1 and out_valid[N] = 1 in the following cycle, with outN unchanged and no ROM slot used.
  - Several hits may complete in the same cycle.
  - Cache entry updates at that voice's CAPT edge.
- Undefined: every request uses a ROM slot; no cache logic.

Test Plan:
- Bench ROM model is a registered 8580 pst table for sel=3: 0x3FF->0x1F, 0x7FF->0x7F, 0xFFF->0xFF, 0x000->0x00.
- Single request: req=001, wave0=0xFFF, sel0=3 -> ack=001 one cycle after grant edge; rom_addr=0xFFF; out0=0xFF with out_valid=001 two edges after grant.
- All three request: waves 0x3FF/0x7FF/0xFFF, sel=3 -> grants 0, 1, 2 at edges E, E+2, E+4; out0=0x1F, out1=0x7F, out2=0xFF; no voice starved.
- Input change after ack: wave0 0x7FF -> 0x000 the cycle after grant -> out0=0x7F, not 0x00.
- Reset asserted in WAIT -> immediately all outputs 0 and state IDLE; no out_valid; after release, req=100 is granted first-in-line correctly (pointer last=2 -> voice 0 priority, voice 2 still served).
- Cache on (SID_WAVE_CACHE_EN): two successive lookups of voice 1 at 0x7FF -> second completes with rom_en never asserted, out1=0x7F; then wave1=0x3FF -> ROM used, out1=0x1F.

Source files
------------

// File: rtl/sid_wave_rom_arbiter.sv
// Round-robin arbiter sharing one registered combined-waveform ROM among three SID voices.
// Optional per-voice result cache enabled by defining SID_WAVE_CACHE_EN.
module sid_wave_rom_arbiter #(
  parameter int NVOICE = 3,
  parameter int AW     = 12,
  parameter int DW     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [AW-1:0]     wave0,
  input  logic [AW-1:0]     wave1,
  input  logic [AW-1:0]     wave2,
  input  logic [1:0]        sel0,
  input  logic [1:0]        sel1,
  input  logic [1:0]        sel2,
  output logic [2:0]        ack,
  output logic              rom_en,
  output logic [AW-1:0]     rom_addr,
  output logic [1:0]        rom_sel,
  input  logic [DW-1:0]     rom_data,
  output logic [DW-1:0]     out0,
  output logic [DW-1:0]     out1,
  output logic [DW-1:0]     out2,
  output logic [2:0]        out_valid,
  output logic [1:0]        dbg_state
);

  // Handshake: req is a level sampled only at grant edges; ack pulses one cycle
  // when the voice's wave/sel were captured; out_valid pulses one cycle when outN updates.

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, CAPT = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [1:0]      last, cur;
  logic [AW-1:0]   wave_v [NVOICE];
  logic [1:0]      sel_v  [NVOICE];
  logic [2:0]      hit, elig;
  logic [2:0]      pick_res;
  logic [1:0]      win;
  logic            grant;
  logic [2:0]      ack_nxt, out_valid_nxt;

  assign wave_v[0] = wave0;
  assign wave_v[1] = wave1;
  assign wave_v[2] = wave2;
  assign sel_v[0]  = sel0;
  assign sel_v[1]  = sel1;
  assign sel_v[2]  = sel2;
  assign dbg_state = state;

`ifdef SID_WAVE_CACHE_EN
  logic [AW+1:0] cache [NVOICE];
  logic [2:0]    cache_vld;

  // A hit is served from the held outN without taking a ROM slot.
  always_comb begin
    hit = 3'b000;
    for (int i = 0; i < NVOICE; i++)
      hit[i] = req[i] && cache_vld[i] && (cache[i] == {sel_v[i], wave_v[i]});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cache_vld <= 3'b000;
      for (int i = 0; i < NVOICE; i++) cache[i] <= '0;
    end else if (state == CAPT) begin
      cache[cur]     <= {rom_sel, rom_addr};
      cache_vld[cur] <= 1'b1;
    end
  end
`else
  assign hit = 3'b000;
`endif

  assign elig = req & ~hit;

  // Search order starts just after the last winner so every voice gets a turn.
  function automatic logic [2:0] pick(input logic [2:0] m, input logic [1:0] l);
    logic [1:0] c0, c1, c2;
    case (l)
      2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
      2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
      default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
    endcase
    if (m[c0])      pick = {1'b1, c0};
    else if (m[c1]) pick = {1'b1, c1};
    else if (m[c2]) pick = {1'b1, c2};
    else            pick = 3'b000;
  endfunction

  always_comb begin
    pick_res = pick(elig, last);
    win      = pick_res[1:0];
    grant    = pick_res[2] && ((state == IDLE) || (state == CAPT));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = grant ? WAIT : IDLE;
      WAIT:    state_nxt = CAPT;
      CAPT:    state_nxt = grant ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_nxt       = hit;
    out_valid_nxt = hit;
    if (grant)         ack_nxt       = ack_nxt | (3'b001 << win);
    if (state == CAPT) out_valid_nxt = out_valid_nxt | (3'b001 << cur);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack       <= 3'b000;
      out_valid <= 3'b000;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      rom_sel   <= 2'd0;
      cur       <= 2'd0;
      last      <= 2'd2;
      out0      <= '0;
      out1      <= '0;
      out2      <= '0;
    end else begin
      ack       <= ack_nxt;
      out_valid <= out_valid_nxt;
      rom_en    <= grant;
      if (grant) begin
        rom_addr <= wave_v[win];
        rom_sel  <= sel_v[win];
        cur      <= win;
        last     <= win;
      end
      if (state == CAPT) begin
        case (cur)
          2'd0:    out0 <= rom_data;
          2'd1:    out1 <= rom_data;
          default: out2 <= rom_data;
        endcase
      end
    end
  end

endmodule
